// File: rtl/ram32768x3.sv
// rtl/ram32768x3.sv - 32768 x 3 single-port colour RAM with post-reset clear sweep.
module ram32768x3 #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 3,
   parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  wren,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  busy
);

   localparam int          CNT_W = ADDR_WIDTH + 1;
   localparam logic [0:0]  CLEAR = 1'b0;
   localparam logic [0:0]  READY = 1'b1;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   logic [0:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rd_q, rd_d;

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_d      = '0;
      mem_we    = 1'b0;
      mem_addr  = address;
      mem_wdata = data;
      if (state_q == CLEAR) begin
         // Sweep zeroes one cell per edge; the edge writing the last cell hands over to READY.
         mem_we    = 1'b1;
         mem_addr  = cnt_q[ADDR_WIDTH-1:0];
         mem_wdata = '0;
         cnt_d     = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(DEPTH - 1)) begin
            state_d = READY;
         end
      end else begin
         mem_we = wren;
         rd_d   = wren ? data : mem[address];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
      end
   end

   // Reset gates the write port so a held reset never touches the array.
   always_ff @(posedge clock) begin
      if (mem_we && !reset) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   assign q    = rd_q;
   assign busy = (state_q == CLEAR);

endmodule

// File: tb/tb_ram32768x3.sv
// tb/tb_ram32768x3.sv - self-checking bench for ram32768x3 against an array reference model.
module tb_ram32768x3;

   localparam int DEPTH = 32768;

   logic        clock;
   logic        reset;
   logic [14:0] address;
   logic [2:0]  data;
   logic        wren;
   logic [2:0]  q;
   logic        busy;

   logic [2:0]  model [0:DEPTH-1];
   int          checks;
   int          errors;

   ram32768x3 dut (
      .clock   (clock),
      .reset   (reset),
      .address (address),
      .data    (data),
      .wren    (wren),
      .q       (q),
      .busy    (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) model[i] = 3'b000;
   endtask

   // Applies one user access in READY and checks the registered result against the model.
   task automatic access(input logic w, input logic [14:0] a, input logic [2:0] d, input string tag);
      wren    = w;
      address = a;
      data    = d;
      step();
      if (w) model[a] = d;
      check(tag, {29'd0, q}, {29'd0, model[a]});
      wren = 1'b0;
   endtask

   // Releases reset and counts edges until busy drops, checking q stays zero and
   // that a user write attempt to 0x0005 during the sweep is ignored.
   task automatic run_sweep(input string tag);
      int n;
      wren    = 1'b1;
      address = 15'h0005;
      data    = 3'b101;
      reset   = 1'b0;
      n = 0;
      while (busy && n < 40000) begin
         step();
         n++;
         if (q !== 3'b000) check({tag, "_q_during_busy"}, {29'd0, q}, 32'd0);
      end
      checks++;
      check({tag, "_busy_edges"}, n, DEPTH);
      wren = 1'b0;
      clear_model();
   endtask

   initial begin
      logic [14:0] a;
      logic [2:0]  d;
      logic [14:0] hot [0:7];
      checks  = 0;
      errors  = 0;
      wren    = 1'b0;
      address = '0;
      data    = '0;
      reset   = 1'b0;

      // Asynchronous reset takes effect without a clock edge.
      #2 reset = 1'b1;
      #1;
      check("reset_q", {29'd0, q}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd1);
      step();
      step();
      check("reset_hold_q", {29'd0, q}, 32'd0);

      // Abort a sweep part-way; it must restart from address 0 and take the full count.
      #1 reset = 1'b0;
      for (int i = 0; i < 100; i++) step();
      check("mid_sweep_busy", {31'd0, busy}, 32'd1);
      #3 reset = 1'b1;
      #1;
      check("mid_sweep_reset_busy", {31'd0, busy}, 32'd1);
      step();
      run_sweep("sweep1");
      check("ready_busy", {31'd0, busy}, 32'd0);

      access(1'b0, 15'h0000, 3'b000, "clr_0000");
      access(1'b0, 15'h4F3B, 3'b000, "clr_4f3b");
      access(1'b0, 15'h7FFF, 3'b000, "clr_7fff");
      access(1'b0, 15'h0005, 3'b000, "busy_write_ignored");

      access(1'b1, 15'b10011110_1110111, 3'b001, "wr_4f77");
      access(1'b0, 15'b10011110_1110111, 3'b000, "rd_4f77");
      access(1'b0, 15'b10011110_1110110, 3'b000, "rd_4f76_neighbour");

      access(1'b1, 15'h0001, 3'b010, "wr_0001_a");
      access(1'b1, 15'h0001, 3'b111, "write_through_0001");
      access(1'b0, 15'h0001, 3'b000, "rd_0001");

      access(1'b1, 15'h7FFF, 3'b110, "wr_7fff");
      access(1'b1, 15'h0000, 3'b011, "wr_0000");
      access(1'b0, 15'h7FFF, 3'b000, "rd_7fff");
      access(1'b0, 15'h0000, 3'b000, "rd_0000");

      // Back-to-back reads on consecutive edges, no idle cycles between them.
      access(1'b0, 15'h0001, 3'b000, "b2b_0");
      access(1'b0, 15'h7FFF, 3'b000, "b2b_1");
      access(1'b0, 15'h0000, 3'b000, "b2b_2");
      access(1'b0, 15'b10011110_1110111, 3'b000, "b2b_3");

      for (int i = 0; i < 8; i++) hot[i] = 15'($urandom);
      for (int i = 0; i < 300; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 15'($urandom) : hot[$urandom_range(0, 7)];
         d = 3'($urandom);
         access(1'($urandom_range(0, 1)), a, d, "random");
      end

      access(1'b1, 15'h0000, 3'b001, "fill_0");
      access(1'b1, 15'h0001, 3'b010, "fill_1");
      access(1'b1, 15'h0002, 3'b100, "fill_2");
      access(1'b1, 15'h0003, 3'b110, "fill_3");
      #3 reset = 1'b1;
      #1;
      check("reset_after_fill_q", {29'd0, q}, 32'd0);
      check("reset_after_fill_busy", {31'd0, busy}, 32'd1);
      step();
      run_sweep("sweep2");
      for (int i = 0; i < 4; i++) access(1'b0, 15'(i), 3'b000, "lost_after_reset");
      for (int i = 0; i < 40; i++) begin
         a = hot[$urandom_range(0, 7)];
         access(1'b0, a, 3'b000, "hot_zero_after_reset");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
